// File: rtl/shared_out_arbiter_if.sv
// Requester-side bundle for the shared output arbiter: request/data in, grant/owner/output back.
// master = requester side (timing_cell outputs); slave = arbiter.
interface shared_out_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 1
);
  logic [N-1:0]         req;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         gnt;
  logic [$clog2(N)-1:0] owner;
  logic [WIDTH-1:0]     out;
  logic                 out_valid;
  logic                 busy;

  modport master (
    output req, in_data,
    input  gnt, owner, out, out_valid, busy
  );

  modport slave (
    input  req, in_data,
    output gnt, owner, out, out_valid, busy
  );
endinterface

// File: rtl/shared_out_arbiter.sv
// Round-robin arbiter serialising N requesters onto one registered shared output.
// Latency: req->gnt 1 cycle, req->out/out_valid 2 cycles. HOLD_TIMEOUT_EN adds forced rotation after MAX_HOLD.
// Backpressure: requesters hold req until granted; the owner keeps gnt until it drops req (or times out).
module shared_out_arbiter #(
  parameter int N        = 4,
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input logic                clk,
  input logic                rst_n,
  shared_out_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_t;

  if (N < 2 || N > 16) begin : g_bad_n
    $error("shared_out_arbiter: N must be in 2..16");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("shared_out_arbiter: MAX_HOLD must be in 1..255");
  end

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] out_q;
  logic            out_valid_q;
  logic [WIDTH-1:0] slice [N];

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign slice[i] = bus.in_data[i*WIDTH +: WIDTH];
  end

  // First set bit of mask at or after start, wrapping modulo N.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] mask, input logic [IW-1:0] start);
    logic [IW-1:0] w;
    logic [IW-1:0] idx;
    logic          found;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(start) + k) % N);
      if (!found && mask[idx]) begin
        found = 1'b1;
        w     = idx;
      end
    end
    return w;
  endfunction

  logic [IW-1:0] nxt;
  logic [N-1:0]  others;
  logic [IW-1:0] win_idle;
  logic [IW-1:0] win_rot;

  assign nxt      = (owner_q == IW'(N-1)) ? '0 : owner_q + IW'(1);
  assign others   = bus.req & ~gnt_q;
  assign win_idle = pick(bus.req, ptr_q);
  assign win_rot  = pick(others, nxt);

`ifdef HOLD_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout;
  assign timeout = (hold_q == 8'(MAX_HOLD)) && (|others);
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef HOLD_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = N'(1) << win_idle;
          owner_d = win_idle;
          state_d = GRANT;
`ifdef HOLD_TIMEOUT_EN
          hold_d  = 8'd1;
`endif
        end
      end
      GRANT: begin
        if (!bus.req[owner_q]) begin
          ptr_d = nxt;
          if (|others) begin
            gnt_d   = N'(1) << win_rot;
            owner_d = win_rot;
`ifdef HOLD_TIMEOUT_EN
            hold_d  = 8'd1;
`endif
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
`ifdef HOLD_TIMEOUT_EN
        else if (timeout) begin
          // Preempted owner keeps requesting and is picked up again in rotation.
          ptr_d   = nxt;
          gnt_d   = N'(1) << win_rot;
          owner_d = win_rot;
          hold_d  = 8'd1;
        end else if (hold_q != 8'(MAX_HOLD)) begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
      hold_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      out_valid_q <= |gnt_q;
      if (|gnt_q) out_q <= slice[owner_q];
`ifdef HOLD_TIMEOUT_EN
      hold_q      <= hold_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.owner     = owner_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = |gnt_q;
endmodule

// File: doc/shared_out_arbiter.md
Name: shared_out_arbiter

Overview:
- Round-robin arbiter and output sequencer for a single shared output net that several timing_cell instances would otherwise drive concurrently.
- Each timing_cell's output stage becomes a requester. The arbiter grants exactly one requester at a time and registers the granted requester's data onto the shared out.
- Sits between the timing_cell outputs and the top-level out port. One clock domain.

Parameters:
- N, 4, number of requesters (2..16).
- WIDTH, 1, data width of each requester and of out.
- MAX_HOLD, 4, maximum consecutive grant cycles before forced rotation (1..255). Used only with HOLD_TIMEOUT_EN.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request. Level-sensitive; held until served.
- in_data  input  N*WIDTH  requester data; slice i = in_data[i*WIDTH +: WIDTH].
- gnt  output  N  registered one-hot grant, or all-zero.
- owner  output  $clog2(N)  registered index of current owner. Equals last owner when idle.
- out  output  WIDTH  registered shared output.
- out_valid  output  1  high when out carries owner data.
- busy  output  1  high when gnt is nonzero.

Behaviour:
- Reset, asynchronous on rst_n low:
  - gnt=0, owner=0, out=0, out_valid=0, busy=0.
  - Priority pointer=0.
  - Hold counter=0.
  - State=IDLE.
- States: IDLE, GRANT.
- IDLE:
  - If req is nonzero at a clock edge, the winner is the first set bit searching from the pointer upward, wrapping modulo N.
  - Registers gnt=onehot(winner), owner=winner, hold=1, and moves to GRANT.
  - Latency from req rise to gnt is 1 cycle.
- GRANT, evaluated each edge in priority order:
  - Release: req[owner]=0.
    - Pointer becomes owner+1 mod N.
    - If any other request is pending, the new winner is granted on the same edge with no idle gap, and hold=1.
    - Otherwise gnt=0 and state returns to IDLE.
  - Timeout (HOLD_TIMEOUT_EN only): hold==MAX_HOLD and any other req is pending.
    - Owner is forcibly released. Winner is chosen among the other requesters from owner+1, and hold=1.
    - Pointer becomes owner+1.
    - The preempted owner's request stays pending and is served in round-robin order.
  - Otherwise: gnt is held, and hold increments, saturating at MAX_HOLD.
- Output datapath:
  - out <= in_data slice[owner] when the registered gnt is nonzero. out is unchanged otherwise.
  - out_valid <= |gnt.
  - out and out_valid therefore lag gnt by 1 cycle; that is, 2 cycles after req.
  - When gnt drops, out_valid falls 1 cycle later and out holds its last value.
- busy = |gnt, driven combinationally from the gnt register.
- gnt is never multi-hot. out never mixes data from two requesters.
- Simultaneous release by the owner and a new request from a lower-index requester: round-robin from owner+1 decides.
- req bits for an index ≥ N do not exist. Widths are exact.
- Reset asserted mid-grant clears everything immediately. First grant after reset goes to the lowest pending index.

Optional Feature:
- Macro HOLD_TIMEOUT_EN.
- Defined: the hold counter and forced rotation after MAX_HOLD cycles are active when contention exists. A lone requester is never preempted.
- Undefined:
  - No hold counter is synthesized. MAX_HOLD is ignored.
  - The owner keeps the grant until it drops req. Rotation happens only on release.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, out=0, out_valid=0. Release reset -> gnt=4'b0001 at first edge, out_valid=1 one edge later.
- Single requester: req=4'b0100, in_data slice2=1, held 10 cycles -> gnt=4'b0100 throughout, owner=2, out=1 from cycle 2. Drop req -> gnt=0 next edge, out_valid=0 one edge after.
- Round-robin fairness without timeout: req=4'b1111, each owner drops req for one cycle after 2 cycles of grant -> grant order 0,1,2,3,0, with no idle cycles between grants.
- Timeout, HOLD_TIMEOUT_EN, MAX_HOLD=4: req0 held high, req3 raised at cycle 5 -> gnt=0001 for 4 cycles, then 1000. Grant returns to 0 when req3 drops or after 4 cycles.
- No timeout, macro undefined: same stimulus -> gnt stays 0001 until req0 drops, then 1000 on that edge.
- Async reset mid-grant: assert rst_n low between edges while gnt=0010 -> gnt, out, and out_valid go to 0 without waiting for clk. Pointer is back to 0.
